// File: rtl/msg_tx_seq_pkg.sv
// Shared definitions for the message transmit sequencer: default marker byte,
// state encoding and the coder-accept edge helper. Optional checksum: MSG_TX_CSUM_EN.
package msg_tx_seq_pkg;

    localparam logic [7:0] MARKER_MASTER = 8'h7E;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MARKER  = 3'd1,
        S_FLAG    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // The coder signals acceptance of a byte by the rising edge of its busy line.
    function automatic logic acc_edge(input logic busy_now, input logic busy_prev);
        return busy_now & ~busy_prev;
    endfunction

    function automatic logic is_send_state(input state_t s);
        return (s == S_MARKER) || (s == S_FLAG) || (s == S_PAYLOAD) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/prio_arb_onehot.sv
// Fixed-priority picker: lowest-index set request wins; one-hot grant plus its index.
module prio_arb_onehot #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt = N_REQ'(1) << i;
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/msg_tx_seq.sv
// Master-side message transmit sequencer: marker, flag, 0..2^LEN_W-1 payload bytes,
// plus a trailing XOR checksum byte when MSG_TX_CSUM_EN is defined.
module msg_tx_seq
    import msg_tx_seq_pkg::*;
#(
    parameter int         N_REQ  = 3,
    parameter int         LEN_W  = 4,
    parameter logic [7:0] MARKER = MARKER_MASTER
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [8*N_REQ-1:0]     req_flag,
    input  logic [LEN_W*N_REQ-1:0] req_len,
    input  logic [7:0]             pl_data,
    output logic                   pl_rd,
    input  logic                   cd_busy,
    output logic [7:0]             q,
    output logic                   q_rdy,
    output logic                   msg_end,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef MSG_TX_CSUM_EN
    localparam state_t TAIL_STATE = S_CSUM;
    logic [7:0] csum_r;
`else
    localparam state_t TAIL_STATE = S_DONE;
`endif

    state_t           state;
    logic             cd_busy_d;
    logic [7:0]       flag_r;
    logic [LEN_W-1:0] cnt;
    logic             acc;
    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [7:0]       sel_flag;
    logic [LEN_W-1:0] sel_len;

    prio_arb_onehot #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req (req),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_flag = req_flag[8*int'(arb_idx) +: 8];
    assign sel_len  = req_len[LEN_W*int'(arb_idx) +: LEN_W];
    assign acc      = acc_edge(cd_busy, cd_busy_d);
    // Held low one cycle after busy falls so the coder sees a clean idle gap.
    assign q_rdy    = is_send_state(state) & ~cd_busy & ~cd_busy_d;

    always_comb begin
        q = 8'h00;
        case (state)
            S_MARKER:  q = MARKER;
            S_FLAG:    q = flag_r;
            S_PAYLOAD: q = pl_data;
`ifdef MSG_TX_CSUM_EN
            S_CSUM:    q = csum_r;
`endif
            default:   q = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            msg_end   <= 1'b0;
            pl_rd     <= 1'b0;
            cd_busy_d <= 1'b0;
            flag_r    <= 8'h00;
            cnt       <= '0;
`ifdef MSG_TX_CSUM_EN
            csum_r    <= 8'h00;
`endif
        end else begin
            cd_busy_d <= cd_busy;
            msg_end   <= 1'b0;
            pl_rd     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The msg_end cycle itself never grants: enforces one idle gap.
                    if (arb_any && !msg_end) begin
                        grant  <= arb_gnt;
                        busy   <= 1'b1;
                        flag_r <= sel_flag;
                        cnt    <= sel_len;
`ifdef MSG_TX_CSUM_EN
                        csum_r <= sel_flag;
`endif
                        state  <= S_MARKER;
                    end
                end
                S_MARKER: if (acc) state <= S_FLAG;
                S_FLAG:   if (acc) state <= (cnt != '0) ? S_PAYLOAD : TAIL_STATE;
                S_PAYLOAD: begin
                    if (acc) begin
                        pl_rd <= 1'b1;
                        cnt   <= cnt - LEN_W'(1);
`ifdef MSG_TX_CSUM_EN
                        csum_r <= csum_r ^ pl_data;
`endif
                        if (cnt == LEN_W'(1)) state <= TAIL_STATE;
                    end
                end
`ifdef MSG_TX_CSUM_EN
                S_CSUM: if (acc) state <= S_DONE;
`endif
                S_DONE: begin
                    if (!cd_busy && !cd_busy_d) begin
                        msg_end <= 1'b1;
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_tx_seq.sv
// Self-checking bench for msg_tx_seq: vector table, hand-written corner sequences and
// randomized messages checked against a byte-stream reference model.
module tb_msg_tx_seq;

    localparam int         N  = 3;
    localparam int         LW = 4;
    localparam logic [7:0] MK = 8'h7E;
`ifdef MSG_TX_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_flag;
    logic [LW*N-1:0] req_len;
    logic [7:0]      pl_data;
    logic            pl_rd;
    logic            cd_busy;
    logic [7:0]      q;
    logic            q_rdy;
    logic            msg_end;
    logic [N-1:0]    grant;
    logic            busy;

    msg_tx_seq #(.N_REQ(N), .LEN_W(LW), .MARKER(MK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_flag (req_flag),
        .req_len  (req_len),
        .pl_data  (pl_data),
        .pl_rd    (pl_rd),
        .cd_busy  (cd_busy),
        .q        (q),
        .q_rdy    (q_rdy),
        .msg_end  (msg_end),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Coder model: sees q_rdy, raises busy next cycle (byte captured), holds hold_cyc cycles.
    int         hold_cyc = 4;
    logic [7:0] sent[$];
    initial begin
        cd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (q_rdy === 1'b1) begin
                @(posedge clk);
                #1;
                cd_busy = 1'b1;
                sent.push_back(q);
                repeat (hold_cyc) @(posedge clk);
                #1 cd_busy = 1'b0;
            end
        end
    end

    // Show-ahead payload source and event counters.
    logic [7:0] pl_src[16];
    int pl_cnt = 0, pl_base = 0, me_cnt = 0, me_cyc = 0, busy_viol = 0;
    int pl_idx;
    assign pl_idx  = pl_cnt - pl_base;
    assign pl_data = (pl_idx >= 0 && pl_idx < 16) ? pl_src[pl_idx] : 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (q_rdy && cd_busy) busy_viol++;
            if (msg_end) begin
                me_cnt++;
                me_cyc = cyc;
            end
            if (pl_rd) pl_cnt++;
        end
    end

    // Reference model: a message is marker, flag, len payload bytes, optional XOR of flag+payload.
    logic [7:0] exp_q[$];
    task automatic add_expected(input int ch, input logic [23:0] f, input logic [11:0] l);
        logic [7:0] fl, cs;
        int len;
        fl  = f[8*ch +: 8];
        len = int'(l[4*ch +: 4]);
        exp_q.push_back(MK);
        exp_q.push_back(fl);
        cs = fl;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pl_src[i]);
            cs = cs ^ pl_src[i];
        end
        if (CS == 1) exp_q.push_back(cs);
    endtask

    function automatic int low_ch(input logic [2:0] r);
        logic [2:0] oh;
        oh = r & (~r + 3'd1);
        return $clog2(oh);
    endfunction

    task automatic compare_bytes(input string nm, input int sb);
        check({nm, " nbytes"}, sent.size() - sb, exp_q.size());
        for (int i = 0; i < exp_q.size() && (sb + i) < sent.size(); i++)
            check($sformatf("%s byte%0d", nm, i), sent[sb + i], exp_q[i]);
    endtask

    task automatic wait_grant(input string nm);
        int n = 0;
        while (grant == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({nm, " grant seen"}, (grant != '0), 1);
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!msg_end && n < 3000);
        check({nm, " msg_end seen"}, msg_end, 1);
    endtask

    task automatic run_msg(input string nm, input logic [2:0] r, input logic [23:0] f,
                           input logic [11:0] l, input int hold, input logic [2:0] exp_g,
                           input int exp_n, input bit mangle);
        int sb, pb, mb, ch;
        ch = low_ch(r);
        exp_q.delete();
        add_expected(ch, f, l);
        hold_cyc = hold;
        sb = sent.size();
        pb = pl_cnt;
        mb = me_cnt;
        pl_base = pl_cnt;
        req_flag = f;
        req_len  = l;
        req      = r;
        wait_grant(nm);
        check({nm, " grant"}, grant, exp_g);
        req = '0;
        if (mangle) begin
            req_len  = ~l;
            req_flag = ~f;
        end
        wait_end(nm);
        @(negedge clk);
        check({nm, " msg_end pulses"}, me_cnt - mb, 1);
        check({nm, " pl_rd pulses"}, pl_cnt - pb, l[4*ch +: 4]);
        check({nm, " sent count"}, sent.size() - sb, exp_n);
        compare_bytes(nm, sb);
        check({nm, " idle grant"}, grant, 0);
        check({nm, " idle busy"}, busy, 0);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [23:0] flags;
        logic [11:0] lens;
        int          hold;
        logic [2:0]  exp_grant;
        int          exp_n;
        bit          mangle;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int sb, pb, mb, e_cyc;
        logic [2:0]  r;
        logic [23:0] f;
        logic [11:0] l;

        rst_n = 1'b0; req = '0; req_flag = '0; req_len = '0;
        for (int k = 0; k < 16; k++) pl_src[k] = 8'((k + 1) * 17);

        tbl[0] = '{3'b010, 24'h33A211, 12'h000, 4,  3'b010, 2 + CS,  1'b0};
        tbl[1] = '{3'b001, 24'h5566C3, 12'h003, 4,  3'b001, 5 + CS,  1'b0};
        tbl[2] = '{3'b100, 24'h9E0000, 12'hF00, 2,  3'b100, 17 + CS, 1'b1};
        tbl[3] = '{3'b111, 24'h010203, 12'h421, 3,  3'b001, 3 + CS,  1'b0};
        tbl[4] = '{3'b110, 24'hB0B1B2, 12'h524, 1,  3'b010, 4 + CS,  1'b0};
        tbl[5] = '{3'b100, 24'h4D0000, 12'h0F0, 20, 3'b100, 2 + CS,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset grant", grant, 0);
        check("reset busy", busy, 0);
        check("reset msg_end", msg_end, 0);
        check("reset pl_rd", pl_rd, 0);
        check("reset q", q, 0);
        check("reset q_rdy", q_rdy, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_msg($sformatf("vec%0d", i), tbl[i].req, tbl[i].flags, tbl[i].lens,
                    tbl[i].hold, tbl[i].exp_grant, tbl[i].exp_n, tbl[i].mangle);

        // Two simultaneous requests: channel 1 first, channel 2 after msg_end + one idle cycle.
        f = 24'hC75A00; l = 12'h201; hold_cyc = 3;
        exp_q.delete();
        add_expected(1, f, l);
        add_expected(2, f, l);
        sb = sent.size(); mb = me_cnt; pl_base = pl_cnt;
        req_flag = f; req_len = l; req = 3'b110;
        wait_grant("pair first");
        check("pair first grant", grant, 3'b010);
        req = 3'b100;
        wait_end("pair first");
        e_cyc = cyc;
        wait_grant("pair second");
        check("pair second grant", grant, 3'b100);
        check("pair gap", cyc - e_cyc, 2);
        req = '0;
        wait_end("pair second");
        @(negedge clk);
        check("pair msg_end pulses", me_cnt - mb, 2);
        compare_bytes("pair", sb);

        // q_rdy drops with cd_busy and stays low one cycle after it falls.
        hold_cyc = 1; req_flag = 24'h000044; req_len = 12'h002; req = 3'b001;
        wait_grant("gap");
        req = '0;
        for (int n = 0; n < 50 && !cd_busy; n++) @(negedge clk);
        check("gap busy high q_rdy", q_rdy, 0);
        @(negedge clk);
        check("gap busy fell", cd_busy, 0);
        check("gap q_rdy extra low", q_rdy, 0);
        @(negedge clk);
        check("gap q_rdy back", q_rdy, 1);
        wait_end("gap");
        @(negedge clk);

        // Reset during the second payload byte drops the message; held req restarts it.
        f = 24'h00006B; l = 12'h003; hold_cyc = 4;
        mb = me_cnt; pb = pl_cnt; pl_base = pl_cnt;
        req_flag = f; req_len = l; req = 3'b001;
        for (int n = 0; n < 500 && (pl_cnt - pb) < 1; n++) @(negedge clk);
        for (int n = 0; n < 50 && !cd_busy; n++) @(negedge clk);
        check("rst at payload2 pl_rd count", pl_cnt - pb, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst mid grant", grant, 0);
        check("rst mid q_rdy", q_rdy, 0);
        check("rst mid busy", busy, 0);
        check("rst mid q", q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb = sent.size(); pb = pl_cnt; pl_base = pl_cnt;
        exp_q.delete();
        add_expected(0, f, l);
        wait_grant("rst restart");
        check("rst restart grant", grant, 3'b001);
        req = '0;
        wait_end("rst restart");
        @(negedge clk);
        check("rst restart msg_end pulses", me_cnt - mb, 1);
        check("rst restart pl_rd", pl_cnt - pb, 3);
        compare_bytes("rst restart", sb);

        // Randomized messages.
        for (int it = 0; it < 40; it++) begin
            int ch;
            r = 3'($urandom_range(1, 7));
            f = 24'($urandom);
            l = 12'($urandom);
            for (int k = 0; k < 16; k++) pl_src[k] = 8'($urandom);
            ch = low_ch(r);
            run_msg($sformatf("rnd%0d", it), r, f, l, $urandom_range(1, 5),
                    3'(1 << ch), 2 + int'(l[4*ch +: 4]) + CS, 1'($urandom));
        end

        check("q_rdy high while cd_busy", busy_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
